// File: rtl/acc_sched_pkg.sv
// acc_sched_pkg: shared types and constants for the accumulator scheduler.
//   state_t      - scheduler FSM states
//   NUM_REQ      - number of byte requesters
//   BYTE_W       - width of a requester byte
//   ST_*         - bit positions inside the status output
package acc_sched_pkg;
    localparam int NUM_REQ   = 2;
    localparam int BYTE_W    = 8;
    localparam int CNT_W     = 4;
    localparam int ST_ACTIVE = 0;
    localparam int ST_LAST   = 1;
    localparam int ST_CNT_LO = 4;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        RD_REQ,
        RD_WAIT_HI,
        RD_WAIT_LO,
        CLR
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, purely combinational.
//   req - per-requester request
//   ptr - requester favoured when both request
//   win - one-hot winner (zero when nothing requests)
module rr_arb2
    import acc_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] win
);
    always_comb begin
        win = req;
        if (req == 2'b11)
            win = ptr ? 2'b10 : 2'b01;
    end
endmodule

// File: rtl/acc_sched.sv
// acc_sched: arbitrates two byte requesters, shifts the granted byte MSB-first
// into the bit-serial accumulator bank, then reads every accumulator result
// out through the UART transmitter.
//   clk, nRst       - clock, async active-low reset
//   req, data0/1    - requests and their bytes
//   gnt             - one-cycle one-hot grant pulse
//   acc_bit, acc_en - serial bit and shift strobe to the accumulators
//   clear           - accumulator clear pulse (only with ACC_SCHED_CLEAR_EN)
//   sel             - accumulator result select during readout
//   uart_start      - one-cycle transmit start; uart_busy from the transmitter
//   status          - [0] active, [1] last winner, [7:4] completed count mod 16
// Build option: define ACC_SCHED_CLEAR_EN to clear the accumulators after each
// readout; otherwise they keep running totals and clear stays 0.
module acc_sched
    import acc_sched_pkg::*;
#(
    parameter int NUM_ACC = 16,
    parameter int SEL_W   = 4
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic [1:0]         req,
    input  logic [7:0]         data0,
    input  logic [7:0]         data1,
    output logic [1:0]         gnt,
    output logic               acc_bit,
    output logic               acc_en,
    output logic               clear,
    output logic [SEL_W-1:0]   sel,
    output logic               uart_start,
    input  logic               uart_busy,
    output logic [7:0]         status
);
    state_t             state, state_n;
    logic [BYTE_W-1:0]  shreg, shreg_n, win_data;
    logic [2:0]         bit_cnt, bit_cnt_n;
    logic [SEL_W-1:0]   sel_n;
    logic [1:0]         gnt_n, win;
    logic               acc_bit_n, acc_en_n, uart_start_n;
    logic               ptr, ptr_n, last_idx, last_n, win_idx, win_idx_n;
    logic               active, active_n, finish;
    logic [CNT_W-1:0]   done_cnt, done_n;

    rr_arb2 u_arb (.req(req), .ptr(ptr), .win(win));

    assign win_data = win[1] ? data1 : data0;

`ifdef ACC_SCHED_CLEAR_EN
    logic clear_q, clear_n;
    assign clear = clear_q;
`else
    assign clear = 1'b0;
`endif

    // Outputs are registered, so each transition computes the values the
    // outputs take in the first cycle of the next state. uart_start is raised
    // on the way into RD_REQ when the transmitter is already idle, and RD_REQ
    // leaves once that pulse has been issued.
    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        bit_cnt_n    = bit_cnt;
        sel_n        = sel;
        gnt_n        = '0;
        acc_bit_n    = 1'b0;
        acc_en_n     = 1'b0;
        uart_start_n = 1'b0;
        win_idx_n    = win_idx;
        active_n     = active;
        ptr_n        = ptr;
        last_n       = last_idx;
        done_n       = done_cnt;
        finish       = 1'b0;
`ifdef ACC_SCHED_CLEAR_EN
        clear_n      = 1'b0;
`endif
        case (state)
            IDLE: if (|req) begin
                state_n   = SHIFT;
                gnt_n     = win;
                win_idx_n = win[1];
                shreg_n   = win_data;
                acc_bit_n = win_data[BYTE_W-1];
                acc_en_n  = 1'b1;
                bit_cnt_n = '0;
                active_n  = 1'b1;
            end
            SHIFT: begin
                shreg_n = shreg << 1;
                if (bit_cnt == 3'(BYTE_W-1)) begin
                    state_n      = RD_REQ;
                    sel_n        = '0;
                    uart_start_n = !uart_busy;
                end else begin
                    bit_cnt_n = bit_cnt + 3'd1;
                    acc_en_n  = 1'b1;
                    acc_bit_n = shreg[BYTE_W-2];
                end
            end
            RD_REQ: begin
                if (uart_start) state_n = RD_WAIT_HI;
                else            uart_start_n = !uart_busy;
            end
            RD_WAIT_HI: if (uart_busy) state_n = RD_WAIT_LO;
            RD_WAIT_LO: if (!uart_busy) begin
                if (sel == SEL_W'(NUM_ACC-1)) begin
`ifdef ACC_SCHED_CLEAR_EN
                    state_n = CLR;
                    clear_n = 1'b1;
`else
                    finish  = 1'b1;
`endif
                end else begin
                    sel_n        = sel + 1'b1;
                    state_n      = RD_REQ;
                    uart_start_n = 1'b1;
                end
            end
            CLR:     finish  = 1'b1;
            default: state_n = IDLE;
        endcase
        // Pointer favours the requester that lost this transaction.
        if (finish) begin
            state_n  = IDLE;
            active_n = 1'b0;
            ptr_n    = ~win_idx;
            last_n   = win_idx;
            done_n   = done_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            sel        <= '0;
            gnt        <= '0;
            acc_bit    <= 1'b0;
            acc_en     <= 1'b0;
            uart_start <= 1'b0;
            win_idx    <= 1'b0;
            active     <= 1'b0;
            ptr        <= 1'b0;
            last_idx   <= 1'b0;
            done_cnt   <= '0;
`ifdef ACC_SCHED_CLEAR_EN
            clear_q    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            sel        <= sel_n;
            gnt        <= gnt_n;
            acc_bit    <= acc_bit_n;
            acc_en     <= acc_en_n;
            uart_start <= uart_start_n;
            win_idx    <= win_idx_n;
            active     <= active_n;
            ptr        <= ptr_n;
            last_idx   <= last_n;
            done_cnt   <= done_n;
`ifdef ACC_SCHED_CLEAR_EN
            clear_q    <= clear_n;
`endif
        end
    end

    always_comb begin
        status                       = '0;
        status[ST_ACTIVE]            = active;
        status[ST_LAST]              = last_idx;
        status[ST_CNT_LO +: CNT_W]   = done_cnt;
    end
endmodule

// File: tb/tb_acc_sched.sv
// tb_acc_sched: randomized self-checking bench for acc_sched. The bench plays
// both requesters and a UART transmitter with random busy timing; a
// transaction-level model (round-robin pointer, winner, byte, completed count)
// predicts every observation. Honors ACC_SCHED_CLEAR_EN for the clear pulse.
module tb_acc_sched;
    localparam int NUM_ACC = 16;
    localparam int SEL_W   = 4;
`ifdef ACC_SCHED_CLEAR_EN
    localparam int EXP_CLR = 1;
`else
    localparam int EXP_CLR = 0;
`endif

    logic             clk, nRst, uart_busy;
    logic [1:0]       req, gnt;
    logic [7:0]       data0, data1, status;
    logic             acc_bit, acc_en, clear, uart_start;
    logic [SEL_W-1:0] sel;

    int n_tests = 0;
    int n_fail  = 0;
    int m_ptr, m_last, m_cnt;
    logic [7:0] last_status;

    acc_sched #(.NUM_ACC(NUM_ACC), .SEL_W(SEL_W)) dut (
        .clk(clk), .nRst(nRst), .req(req), .data0(data0), .data1(data1),
        .gnt(gnt), .acc_bit(acc_bit), .acc_en(acc_en), .clear(clear),
        .sel(sel), .uart_start(uart_start), .uart_busy(uart_busy),
        .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outvec();
        return {14'd0, gnt, acc_bit, acc_en, clear, sel, uart_start, status};
    endfunction

    // One complete transaction: raise requests, act as UART, observe until
    // the scheduler returns to idle, then compare against the model.
    task automatic run_txn(input logic [1:0] rq, input logic [7:0] d0,
                           input logic [7:0] d1, input int bp);
        int w, cyc, ngnt, gcyc, nbits, fbit, nstart, fstart, nclr, fact;
        int sel_err, start_err, clr_err, rise_wait, busy_left, exp_first;
        logic [1:0] gval;
        logic [7:0] cap, exp_byte, end_status, exp_st;
        logic [SEL_W-1:0] exp_sel;
        bit done, seen_act, pend, prev_busy;

        w = (rq == 2'b11) ? m_ptr : (rq[1] ? 1 : 0);
        exp_byte = (w == 1) ? d1 : d0;
        cyc = 0; ngnt = 0; gcyc = 0; nbits = 0; fbit = 0; nstart = 0; fstart = 0;
        nclr = 0; fact = 0; sel_err = 0; start_err = 0; clr_err = 0;
        rise_wait = 0; busy_left = 0; gval = '0; cap = '0; exp_sel = '0;
        end_status = '0; done = 0; seen_act = 0; pend = 0;

        @(negedge clk);
        req = rq; data0 = d0; data1 = d1;
        uart_busy = (bp > 0);
        prev_busy = uart_busy;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (gnt != 2'b00) begin
                ngnt++; gval = gnt; gcyc = cyc;
                req = req & ~gnt;
            end
            if (acc_en) begin
                cap = {cap[6:0], acc_bit};
                nbits++;
                if (fbit == 0) fbit = cyc;
            end
            if (uart_start) begin
                if (prev_busy) start_err++;
                if (sel != exp_sel) sel_err++;
                exp_sel = exp_sel + 1'b1;
                nstart++;
                if (fstart == 0) fstart = cyc;
            end else if (nbits == 8 && !acc_en && nstart == 0 && sel != '0) begin
                sel_err++;
            end
            if (clear) begin
                nclr++;
                if (nstart != NUM_ACC) clr_err++;
            end
            if (status[0]) begin
                seen_act = 1;
                if (fact == 0) fact = cyc;
            end else if (seen_act) begin
                done = 1;
                req  = '0;
            end
            end_status = status;
            if (uart_start) begin
                pend = 1;
                rise_wait = $urandom_range(0, 2);
                busy_left = $urandom_range(2, 4);
            end
            if (cyc < bp) uart_busy = 1'b1;
            else if (pend && rise_wait > 0) begin
                rise_wait--; uart_busy = 1'b0;
            end else if (pend && busy_left > 0) begin
                busy_left--; uart_busy = 1'b1;
                if (busy_left == 0) pend = 0;
            end else uart_busy = 1'b0;
            prev_busy = uart_busy;
        end

        m_ptr  = 1 - w;
        m_last = w;
        m_cnt  = (m_cnt + 1) % 16;
        last_status = end_status;
        exp_st = {4'(m_cnt), 2'b00, 1'(m_last), 1'b0};
        exp_first = (bp + 1 > 9) ? bp + 1 : 9;

        chk("done",       32'(done), 1);
        chk("gnt_cnt",    ngnt, 1);
        chk("gnt_val",    32'(gval), (w == 1) ? 2 : 1);
        chk("gnt_cyc",    gcyc, 1);
        chk("act_cyc",    fact, 1);
        chk("acc_en_cnt", nbits, 8);
        chk("first_bit",  fbit, 1);
        chk("byte",       32'(cap), 32'(exp_byte));
        chk("starts",     nstart, NUM_ACC);
        chk("first_start", fstart, exp_first);
        chk("sel_seq",    sel_err, 0);
        chk("start_busy", start_err, 0);
        chk("clears",     nclr, EXP_CLR);
        chk("clr_order",  clr_err, 0);
        chk("status",     32'(end_status), 32'(exp_st));
    endtask

    initial begin
        nRst = 1'b0; req = '0; data0 = '0; data1 = '0; uart_busy = 1'b0;
        m_ptr = 0; m_last = 0; m_cnt = 0; last_status = '0;
        repeat (2) @(negedge clk);
        chk("rst_outs", outvec(), 0);
        nRst = 1'b1;

        // Tie from reset grants requester 0, then requester 1.
        run_txn(2'b11, 8'h3C, 8'hC3, 0);
        run_txn(2'b11, 8'h5A, 8'h96, 0);

        // Reset in the middle of SHIFT discards the transaction.
        @(negedge clk);
        req = 2'b10; data1 = 8'hFF;
        repeat (3) @(negedge clk);
        nRst = 1'b0;
        #1;
        chk("rst_mid", outvec(), 0);
        req = '0;
        @(negedge clk);
        nRst = 1'b1;
        m_ptr = 0; m_last = 0; m_cnt = 0;

        // Directed single request, then 20+ cycles of back-pressure at RD_REQ.
        run_txn(2'b01, 8'hA5, 8'h00, 0);
        run_txn(2'b10, 8'h00, 8'h81, 29);

        // Random traffic; 17 completed transactions since reset in total.
        for (int i = 0; i < 15; i++) begin
            logic [1:0] rq;
            int bp;
            rq = 2'($urandom_range(1, 3));
            bp = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 30) : 0;
            run_txn(rq, 8'($urandom), 8'($urandom), bp);
        end
        chk("cnt_wrap", 32'(last_status[7:4]), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
